// File: rtl/gray_to_bin_pipe.sv
// Pipelined Gray-to-binary decoder with a valid/ready elastic pipeline.
// Each stage resolves one chunk of the prefix-XOR chain, from the MSB downward.
`timescale 1ns/1ps

module gray_to_bin_pipe #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  data_in_valid_i,
  output logic                  data_in_ready_o,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_out_valid_o,
  input  logic                  data_out_ready_i
);

  localparam int unsigned CHUNK = (DATA_WIDTH + NUM_STAGES - 1) / NUM_STAGES;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // One register per stage: bits above the stage's low bound are already binary,
  // bits below are still Gray, so a single word carries both halves.
  logic  [NUM_STAGES-1:0] valid_q, valid_d;
  word_t [NUM_STAGES-1:0] word_q, word_d;

  logic  [NUM_STAGES-1:0] rdy_c;
  logic  [NUM_STAGES-1:0] valid_in_c;
  word_t [NUM_STAGES-1:0] word_in_c;

  // Ready chain: a stage can load if it is empty or its successor can load.
  always_comb begin
    logic rdy;
    rdy   = data_out_ready_i;
    rdy_c = '0;
    for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
      rdy      = !valid_q[s] | rdy;
      rdy_c[s] = rdy;
    end
  end

  always_comb begin
    valid_in_c    = '0;
    word_in_c     = '0;
    valid_in_c[0] = data_in_valid_i;
    word_in_c[0]  = data_in_i;
    for (int s = 1; s < int'(NUM_STAGES); s++) begin
      valid_in_c[s] = valid_q[s-1];
      word_in_c[s]  = word_q[s-1];
    end
  end

  // Next state: each stage resolves bins hi..lo, carrying in the bin just above.
  always_comb begin
    word_t w;
    logic  carry;
    int    hi;
    int    lo;
    valid_d = valid_q;
    word_d  = word_q;
    w       = '0;
    carry   = 1'b0;
    hi      = 0;
    lo      = 0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      if (rdy_c[s]) begin
        valid_d[s] = valid_in_c[s];
      end
      if (rdy_c[s] && valid_in_c[s]) begin
        w     = word_in_c[s];
        carry = 1'b0;
        hi    = int'(DATA_WIDTH) - 1 - s * int'(CHUNK);
        lo    = int'(DATA_WIDTH) - (s + 1) * int'(CHUNK);
        if (lo < 0) begin
          lo = 0;
        end
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
          if (i <= hi && i >= lo) begin
            w[i] = w[i] ^ carry;
          end
          carry = w[i];
        end
        word_d[s] = w;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign data_in_ready_o  = rdy_c[0];
  assign data_out_o       = word_q[NUM_STAGES-1];
  assign data_out_valid_o = valid_q[NUM_STAGES-1];

endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Directed bench for gray_to_bin_pipe: vector table, streaming, backpressure,
// exhaustive Gray sweep with random gaps, and mid-stream reset.
`timescale 1ns/1ps

module tb_gray_to_bin_pipe;

  localparam int unsigned W  = 11;
  localparam int unsigned NS = 2;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] data_in_i;
  logic         data_in_valid_i;
  logic         data_in_ready_o;
  logic [W-1:0] data_out_o;
  logic         data_out_valid_o;
  logic         data_out_ready_i;

  int checks   = 0;
  int failures = 0;
  bit abort    = 1'b0;
  logic [W-1:0] got_q[$];

  always #5 clk_i = ~clk_i;

  gray_to_bin_pipe #(.DATA_WIDTH(W), .NUM_STAGES(NS)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .data_in_i        (data_in_i),
    .data_in_valid_i  (data_in_valid_i),
    .data_in_ready_o  (data_in_ready_o),
    .data_out_o       (data_out_o),
    .data_out_valid_o (data_out_valid_o),
    .data_out_ready_i (data_out_ready_i)
  );

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    b[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    abort = 1'b1;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one word and hold it until the handshake completes.
  task automatic send(input logic [W-1:0] w);
    bit done;
    done = 1'b0;
    if (abort) return;
    data_in_i       = w;
    data_in_valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (data_in_ready_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) timeout("send");
    step();
    data_in_valid_i = 1'b0;
  endtask

  // Capture completed output transfers; optionally randomise ready each cycle.
  task automatic collect(input int n, input bit rand_ready, input int budget);
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      @(negedge clk_i);
      if (data_out_valid_o && data_out_ready_i) got_q.push_back(data_out_o);
      step();
      if (rand_ready) data_out_ready_i = ($urandom_range(0, 3) != 0);
    end
    if (got_q.size() < n) timeout("collect");
  endtask

  initial begin
    int edges;
    bit seen;
    logic [W-1:0] bp_words[4];
    logic [W-1:0] sent_q[$];

    vecs[0] = '{11'h7FF, 11'h555};
    vecs[1] = '{11'h600, 11'h400};
    vecs[2] = '{11'h001, 11'h001};
    vecs[3] = '{11'h000, 11'h000};
    vecs[4] = '{11'h400, 11'h7FF};
    vecs[5] = '{11'h003, 11'h002};
    vecs[6] = '{11'h020, 11'h03F};
    vecs[7] = '{11'h040, 11'h07F};
    vecs[8] = '{11'h2AA, 11'h333};
    vecs[9] = '{11'h030, 11'h020};

    rst_i            = 1'b1;
    data_in_i        = '0;
    data_in_valid_i  = 1'b0;
    data_out_ready_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_valid", 32'(data_out_valid_o), 32'd0);
    check("reset_data",  32'(data_out_o),       32'd0);
    check("reset_ready", 32'(data_in_ready_o),  32'd1);

    // Single words: latency in edges, decoded value, and drain.
    for (int v = 0; v < 10; v++) begin
      data_in_i       = vecs[v].gray;
      data_in_valid_i = 1'b1;
      edges = 0;
      seen  = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step();
        data_in_valid_i = 1'b0;
        edges++;
        if (data_out_valid_o) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) timeout($sformatf("vec%0d_valid", v));
      check($sformatf("vec%0d_latency", v), 32'(edges), 32'(NS));
      check($sformatf("vec%0d_data", v), 32'(data_out_o), 32'(vecs[v].bin));
      step();
      check($sformatf("vec%0d_drained", v), 32'(data_out_valid_o), 32'd0);
      @(negedge clk_i);
    end

    // Back-to-back stream at full throughput.
    step();
    fork
      begin
        send(11'h600);
        send(11'h001);
        send(11'h000);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk_i);
          if (data_out_valid_o) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) timeout("b2b_first");
        check("b2b_w0", 32'(data_out_o), 32'h400);
        @(negedge clk_i);
        check("b2b_v1", 32'(data_out_valid_o), 32'd1);
        check("b2b_w1", 32'(data_out_o), 32'h001);
        @(negedge clk_i);
        check("b2b_v2", 32'(data_out_valid_o), 32'd1);
        check("b2b_w2", 32'(data_out_o), 32'h000);
      end
    join
    repeat (4) step();

    // Backpressure: output stalled for 5 cycles while 4 words are offered.
    bp_words[0] = 11'h7FF;
    bp_words[1] = 11'h2AA;
    bp_words[2] = 11'h030;
    bp_words[3] = 11'h600;
    got_q.delete();
    data_out_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp_words[i]);
      end
      begin
        for (int cyc = 1; cyc <= 5; cyc++) begin
          @(negedge clk_i);
          if (cyc == 3) begin
            check("bp_in_ready_low", 32'(data_in_ready_o), 32'd0);
            check("bp_out_valid", 32'(data_out_valid_o), 32'd1);
          end
          if (cyc >= 3) check($sformatf("bp_hold%0d", cyc), 32'(data_out_o), 32'h555);
        end
        step();
        data_out_ready_i = 1'b1;
        collect(4, 1'b0, 40);
      end
    join
    check("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'(gray2bin(bp_words[i])));
    repeat (4) step();

    // Exhaustive sweep of every Gray code with random valid and ready gaps.
    got_q.delete();
    sent_q.delete();
    fork
      begin
        for (int i = 0; i < (1 << W); i++) begin
          logic [W-1:0] g;
          g = W'(i) ^ (W'(i) >> 1);
          if ($urandom_range(0, 3) == 0) step();
          sent_q.push_back(g);
          send(g);
        end
      end
      collect(1 << W, 1'b1, 20000);
    join
    data_out_ready_i = 1'b1;
    check("exh_count", 32'(got_q.size()), 32'd2048);
    for (int k = 0; k < got_q.size() && k < sent_q.size(); k++)
      check($sformatf("exh_word%0d", k), 32'(got_q[k]), 32'(gray2bin(sent_q[k])));
    repeat (4) step();

    // Mid-stream reset with the pipe full; stale words must never appear.
    data_out_ready_i = 1'b0;
    send(11'h7FF);
    send(11'h600);
    @(negedge clk_i);
    check("mrst_full_ready", 32'(data_in_ready_o), 32'd0);
    step();
    rst_i           = 1'b1;
    data_in_i       = 11'h001;
    data_in_valid_i = 1'b1;
    step();
    check("mrst_valid", 32'(data_out_valid_o), 32'd0);
    check("mrst_data",  32'(data_out_o),       32'd0);
    check("mrst_ready", 32'(data_in_ready_o),  32'd1);
    rst_i            = 1'b0;
    data_in_valid_i  = 1'b0;
    data_out_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      check($sformatf("mrst_no_stale%0d", k), 32'(data_out_valid_o), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
